spi_peripheral: RTL and testbench
=================================

# spi_peripheral

SPI target (mode 0, write-only) that sits directly upstream of the PWM peripheral in the TinyTapeout top. It samples the raw SPI pins from `ui_in`, oversamples them in the system clock domain, decodes 16-bit write frames, and drives the five configuration registers the PWM stage consumes: `en_reg_out_7_0`, `en_reg_out_15_8`, `en_reg_pwm_7_0`, `en_reg_pwm_15_8` and `pwm_duty_cycle`.

## Interface
Parameters:
- `FRAME_BITS`, 16: bits per transaction; 1 R/W + 7 address + 8 data.
- `MAX_ADDR`, 4: highest valid register address.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `sclk`  in  1  SPI clock, async to `clk` (`ui_in[0]`).
- `copi`  in  1  SPI data in, async (`ui_in[1]`).
- `ncs`  in  1  SPI chip select, active-low, async (`ui_in[2]`).
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.
- `wr_strobe`  out  1  one-`clk` pulse on each committed write.

## Operation
- `sclk`, `copi` and `ncs` each pass through a 2-flop synchronizer. A third flop on `sclk` and `ncs` gives rising/falling-edge detection in the `clk` domain.
- States: IDLE, SHIFT.
  - IDLE → SHIFT on a synchronized `ncs` falling edge. This clears the 16-bit shift register and the 5-bit bit counter.
  - In SHIFT, each synchronized `sclk` rising edge shifts the synchronized `copi` in MSB-first and increments the counter. The counter saturates at 17, which means overrun.
  - SHIFT → IDLE on a synchronized `ncs` rising edge. At that point the frame is evaluated.
- Commit rule: commit only if the counter equals exactly 16, bit 15 = 1 (write), and bits 14:8 ≤ `MAX_ADDR`.
  - A commit loads bits 7:0 into the addressed register and pulses `wr_strobe`.
  - Any other frame is discarded silently: read frames (bit 15 = 0), short frames, long frames, and out-of-range addresses. No register changes.
- `sclk` edges while `ncs` is high are ignored.
- Registers hold their value indefinitely between writes. There is no read-back path; `cipo` is not driven.
- Reset mid-frame: all state returns to IDLE and all registers clear. A frame in progress when `rst` deasserts is ignored until the next `ncs` falling edge.

## Timing
- Reset values: all five registers 0x00, `wr_strobe` 0, state IDLE, shift register and counter 0.
- Pin-to-detected-edge latency: 3 `clk` cycles (two synchronizer stages plus the edge-detect flop).
- A committed register updates on the `clk` edge after the `ncs` rising edge is detected. That is 4 `clk` cycles after the `ncs` pin rises. `wr_strobe` is high during that same cycle.
- Supported SCLK: ≤ `clk`/8. Each SCLK high and low phase must last ≥ 4 `clk` cycles.
- `copi` must be stable ≥ 4 `clk` cycles around the SCLK rising edge.
- `ncs` high time between frames: ≥ 4 `clk` cycles. Back-to-back frames meeting this rule must both commit.
- Outputs are registered; there is no combinational path from input pins to outputs.

## Structure
- Shared package `spi_pkg`:
  - register address constants `ADDR_EN_OUT_LO` = 0, `ADDR_EN_OUT_HI` = 1, `ADDR_EN_PWM_LO` = 2, `ADDR_EN_PWM_HI` = 3, `ADDR_DUTY` = 4;
  - `FRAME_BITS`;
  - the state enum.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus edge flop, outputs `level`, `rise`, `fall`. Instantiated for `sclk` and `ncs`. `copi` uses the level output only.
- The top-level TinyTapeout wrapper instantiates `spi_peripheral` and connects its five register outputs to the PWM peripheral.

## Test plan
- **Valid write:** frame 0x80F0 (write, addr 0, data 0xF0) → `en_reg_out_7_0` = 0xF0 four `clk` cycles after `ncs` rises; `wr_strobe` pulses once; other registers stay 0x00.
- **Read frame and bad address:**
  - 0x04AA (read, addr 4) → `pwm_duty_cycle` unchanged, no strobe.
  - 0x8555 (addr 5) → nothing changes.
- **Wrong length:**
  - 15 clocks of 0x8433 → no change.
  - 17 clocks → no change.
  - A following valid 16-bit 0x8480 → `pwm_duty_cycle` = 0x80.
- **All registers, back-to-back:** writes 0x8001, 0x8102, 0x8204, 0x8308, 0x8410 with 4-cycle `ncs` gaps → registers read 0x01/0x02/0x04/0x08/0x10 and five strobes are seen.
- **Reset mid-frame:** assert `rst` after 8 bits of 0x84FF, release, finish the frame → no commit; all registers 0x00.
- **Noise:** toggle `sclk` and `copi` with `ncs` high → no state change; a subsequent valid frame commits normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write-only configuration target:
// frame geometry, register map and controller state encoding.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [ADDR_BITS-1:0] ADDR_DUTY      = 7'd4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin, followed by one edge flop.
// The rise/fall pulses are registered, so a pin edge is seen three clk edges later.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchronizer chain plus registered edge detection; resets low so a pin
    // that is already low at reset release never reports a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    assign level = sync2_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only target: decodes 16-bit frames (R/W, 7-bit address,
// 8-bit data) and drives the five PWM configuration registers.
module spi_peripheral #(
    parameter int FRAME_BITS = 16,
    parameter int MAX_ADDR   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    import spi_pkg::*;

    localparam logic [4:0]           FULL_CNT    = 5'(FRAME_BITS);
    localparam logic [4:0]           OVERRUN_CNT = 5'(FRAME_BITS + 1);
    localparam logic [ADDR_BITS-1:0] MAX_ADDR_C  = 7'(MAX_ADDR);

    logic sclk_level_s, sclk_rise_s, sclk_fall_s;
    logic ncs_level_s, ncs_rise_s, ncs_fall_s;
    logic copi_s, copi_rise_s, copi_fall_s;
    logic unused_s;

    spi_state_e            state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [4:0]            bit_cnt_r;
    logic                  wr_strobe_r;
    logic [7:0]            en_out_lo_r, en_out_hi_r, en_pwm_lo_r, en_pwm_hi_r, duty_r;

    logic [ADDR_BITS-1:0]  addr_s;
    logic [DATA_BITS-1:0]  data_s;
    logic                  frame_ok_s;

    sync_edge_detect u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    sync_edge_detect u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .din   (ncs),
        .level (ncs_level_s),
        .rise  (ncs_rise_s),
        .fall  (ncs_fall_s)
    );

    sync_edge_detect u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .din   (copi),
        .level (copi_s),
        .rise  (copi_rise_s),
        .fall  (copi_fall_s)
    );

    assign unused_s = &{sclk_level_s, sclk_fall_s, ncs_level_s, copi_rise_s, copi_fall_s};

    assign addr_s     = shift_r[FRAME_BITS-2 -: ADDR_BITS];
    assign data_s     = shift_r[DATA_BITS-1:0];
    assign frame_ok_s = (bit_cnt_r == FULL_CNT) && shift_r[FRAME_BITS-1] && (addr_s <= MAX_ADDR_C);

    // Frame controller: collect bits while selected, commit on deselect if the
    // frame is an in-range write of exactly FRAME_BITS bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= {FRAME_BITS{1'b0}};
            bit_cnt_r   <= 5'd0;
            wr_strobe_r <= 1'b0;
            en_out_lo_r <= 8'h00;
            en_out_hi_r <= 8'h00;
            en_pwm_lo_r <= 8'h00;
            en_pwm_hi_r <= 8'h00;
            duty_r      <= 8'h00;
        end else begin
            wr_strobe_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ncs_fall_s) begin
                        state_r   <= SHIFT;
                        shift_r   <= {FRAME_BITS{1'b0}};
                        bit_cnt_r <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise_s) begin
                        state_r <= IDLE;
                        if (frame_ok_s) begin
                            wr_strobe_r <= 1'b1;
                            case (addr_s)
                                ADDR_EN_OUT_LO: en_out_lo_r <= data_s;
                                ADDR_EN_OUT_HI: en_out_hi_r <= data_s;
                                ADDR_EN_PWM_LO: en_pwm_lo_r <= data_s;
                                ADDR_EN_PWM_HI: en_pwm_hi_r <= data_s;
                                ADDR_DUTY:      duty_r      <= data_s;
                                default:        wr_strobe_r <= 1'b0;
                            endcase
                        end
                    end else if (sclk_rise_s) begin
                        shift_r <= {shift_r[FRAME_BITS-2:0], copi_s};
                        // Saturate one past a full frame so long frames stay rejected.
                        if (bit_cnt_r != OVERRUN_CNT) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = en_out_lo_r;
    assign en_reg_out_15_8 = en_out_hi_r;
    assign en_reg_pwm_7_0  = en_pwm_lo_r;
    assign en_reg_pwm_15_8 = en_pwm_hi_r;
    assign pwm_duty_cycle  = duty_r;
    assign wr_strobe       = wr_strobe_r;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral: bit-banged SPI frames with
// hand-computed register expectations and wr_strobe pulse counting.
module tb_spi_peripheral;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    int checks_r;
    int failures_r;
    int strobe_cnt_r;

    spi_peripheral #(
        .FRAME_BITS (16),
        .MAX_ADDR   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobe cycles on the edge opposite to the active one.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt_r = strobe_cnt_r + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check_eq($sformatf("%s_r0", tag), 32'(en_reg_out_7_0),  32'(e0));
        check_eq($sformatf("%s_r1", tag), 32'(en_reg_out_15_8), 32'(e1));
        check_eq($sformatf("%s_r2", tag), 32'(en_reg_pwm_7_0),  32'(e2));
        check_eq($sformatf("%s_r3", tag), 32'(en_reg_pwm_15_8), 32'(e3));
        check_eq($sformatf("%s_r4", tag), 32'(pwm_duty_cycle),  32'(e4));
    endtask

    // Advance n clock edges and settle just after the last one.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift nbits of data MSB-first, 4-cycle setup/high/low phases; ncs untouched.
    task automatic shift_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = data[i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
        wait_clks(4);
    endtask

    // Complete frame: select, shift, deselect, then hold ncs high for gap cycles.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int gap);
        ncs = 1'b0;
        wait_clks(4);
        shift_bits(data, nbits);
        ncs = 1'b1;
        wait_clks(gap);
    endtask

    initial begin
        checks_r     = 0;
        failures_r   = 0;
        strobe_cnt_r = 0;
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        wait_clks(4);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("reset_strobe", 32'(wr_strobe), 32'd0);
        rst = 1'b0;
        wait_clks(8);

        // Valid write with exact commit latency: 4 clk edges after ncs rises.
        ncs = 1'b0;
        wait_clks(4);
        shift_bits(32'h0000_80F0, 16);
        ncs = 1'b1;
        wait_clks(3);
        check_eq("lat3_reg", 32'(en_reg_out_7_0), 32'h00);
        check_eq("lat3_strobe", 32'(wr_strobe), 32'd0);
        wait_clks(1);
        check_eq("lat4_reg", 32'(en_reg_out_7_0), 32'hF0);
        check_eq("lat4_strobe", 32'(wr_strobe), 32'd1);
        wait_clks(1);
        check_eq("lat5_strobe", 32'(wr_strobe), 32'd0);
        wait_clks(4);
        check_regs("write0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("write0_strobes", 32'(strobe_cnt_r), 32'd1);

        // Read frame and out-of-range address are dropped.
        send_frame(32'h0000_04AA, 16, 8);
        check_regs("read", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(32'h0000_8555, 16, 8);
        check_regs("badaddr", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("drop_strobes", 32'(strobe_cnt_r), 32'd1);

        // Short (15) and long (17) frames are dropped; a following good frame commits.
        send_frame(32'h0000_4219, 15, 8);
        check_eq("short_duty", 32'(pwm_duty_cycle), 32'h00);
        send_frame(32'h0001_0867, 17, 8);
        check_eq("long_duty", 32'(pwm_duty_cycle), 32'h00);
        check_eq("len_strobes", 32'(strobe_cnt_r), 32'd1);
        send_frame(32'h0000_8480, 16, 8);
        check_eq("after_len_duty", 32'(pwm_duty_cycle), 32'h80);
        check_eq("after_len_strobes", 32'(strobe_cnt_r), 32'd2);

        // Back-to-back writes to every register with minimum ncs gap.
        send_frame(32'h0000_8001, 16, 4);
        send_frame(32'h0000_8102, 16, 4);
        send_frame(32'h0000_8204, 16, 4);
        send_frame(32'h0000_8308, 16, 4);
        send_frame(32'h0000_8410, 16, 8);
        check_regs("b2b", 8'h01, 8'h02, 8'h04, 8'h08, 8'h10);
        check_eq("b2b_strobes", 32'(strobe_cnt_r), 32'd7);

        // Reset mid-frame, then finish the frame: nothing commits.
        ncs = 1'b0;
        wait_clks(4);
        shift_bits(32'h0000_0084, 8);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        shift_bits(32'h0000_00FF, 8);
        ncs = 1'b1;
        wait_clks(8);
        check_regs("after_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("rst_strobes", 32'(strobe_cnt_r), 32'd7);

        // Noise on sclk/copi while deselected is ignored; next frame commits.
        for (int i = 0; i < 6; i++) begin
            copi = (i % 2 == 0) ? 1'b1 : 1'b0;
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
        ncs = 1'b1;
        wait_clks(8);
        check_regs("noise", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("noise_strobes", 32'(strobe_cnt_r), 32'd7);
        send_frame(32'h0000_8133, 16, 8);
        check_regs("post_noise", 8'h00, 8'h33, 8'h00, 8'h00, 8'h00);
        check_eq("post_noise_strobes", 32'(strobe_cnt_r), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
